poly_ram_reader: RTL and testbench
==================================

Name: poly_ram_reader

Overview:
- Read-side companion to the polynomial RAM (96-bit words, 256 deep, 8 packed 12-bit coefficients per word).
- The coefficient writers (coder, NTT, A generator, CBD) fill this RAM. This block drains it: it fetches a run of words from a start offset and streams unpacked coefficients downstream on a valid/ready interface.
- It absorbs the RAM's 1-cycle read latency and downstream backpressure without losing or duplicating data.
- Its consumers are serializer/hash-input paths and the bench monitor.

Parameters:
- DATA_W, 96, RAM word width.
- ADDR_W, 8, RAM address width.
- COEF_W, 12, coefficient width.
- COEFS_PER_WORD, 8, equal to DATA_W/COEF_W.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-low.
- start  in  1  one-cycle request; sampled only in IDLE.
- r_start_offset  in  8  first RAM word address.
- word_count  in  9  number of words to read, range 0..256.
- ram_raddr  out  8  RAM read address.
- ram_rdata  in  96  RAM read data, valid exactly 1 cycle after ram_raddr is presented.
- coef_valid  out  1  coefficient available.
- coef_ready  in  1  downstream accepts.
- coef_data  out  12  coefficient.
- coef_index  out  8  coefficient position within its 256-coefficient polynomial.
- coef_last  out  1  final coefficient of the run.
- busy  out  1  high outside IDLE.
- done  out  1  one-cycle pulse when the run completes.

Behaviour:
- Reset (rst=0 at a clock edge): all outputs 0; FSM to IDLE; FIFO, counters and serializer cleared. Applies mid-run as well; any in-flight RAM read is discarded.
- FSM states: IDLE, FETCH, DRAIN, DONE.
  - IDLE -> FETCH on start with word_count != 0. Offset and count are latched.
  - IDLE -> DONE on start with word_count == 0. No read is issued and coef_valid never rises.
  - FETCH -> DRAIN once all word_count reads have been issued.
  - DRAIN -> DONE when the last coefficient handshakes.
  - DONE -> IDLE unconditionally. done=1 only in DONE.
- start is ignored in every state other than IDLE.
- Read issue:
  - In FETCH, issue one read per cycle at ram_raddr = offset + issued_count (mod 256). Addresses wrap from 0xFF to 0x00.
  - A read is issued only if (FIFO occupancy + reads in flight) < 2.
  - ram_raddr holds its last value when no read is issued; it is 0 in IDLE.
- Word FIFO:
  - 2 entries of DATA_W bits.
  - ram_rdata is captured 1 cycle after issue.
  - Overflow is impossible by construction; an assertion checks it.
- Serializer:
  - Holds the current word. Coefficient k = word[COEF_W*k +: COEF_W], emitted k = 0 first.
  - Advances on coef_valid & coef_ready.
  - After coefficient 7 is accepted it loads the next FIFO word in the same cycle, so there is no bubble when data is available.
- Output stability: coef_valid, coef_data, coef_index and coef_last hold steady while coef_valid=1 and coef_ready=0.
- coef_index:
  - Starts at 0 at run start and increments by 1 per accepted coefficient, wrapping 255 -> 0 every 32 words.
  - It is independent of r_start_offset alignment.
- coef_last = 1 only on coefficient 7 of word word_count-1.
- Latency: with coef_ready held high, start sampled at cycle T gives the first read at T+1, data captured at T+2, and coef_valid=1 at T+3.
- Throughput: 1 coefficient per cycle sustained. A 256-word run with ready high completes its final handshake at T+3+2047, and done pulses the following cycle.
- Width rules:
  - Coefficients are passed through unmodified; there is no modular reduction.
  - Issued/accepted word counters are 9 bits so word_count = 256 is exact.

Decomposition:
- Shared package: DATA_W, ADDR_W, COEF_W, COEFS_PER_WORD, the FSM state encoding, and POLY_WORDS = 32.
- One natural sub-module, word_fifo2: a 2-entry synchronous FIFO with push/pop/full/empty/count.
- The FSM, read issue and serializer live in poly_ram_reader.

Test Plan:
- Single word: offset 0x10, word_count 1, RAM[0x10] = coefficients 0x001..0x008 packed low-first, ready high -> ram_raddr=0x10 at T+1; coef_data 0x001..0x008 on cycles T+3..T+10, coef_index 0..7, coef_last on 0x008; done at T+11.
- Full polynomial: offset 0x20, word_count 32, ready high -> 256 consecutive valid cycles with no bubble; coef_index 0..255; data matches RAM contents; exactly one done.
- Backpressure: word_count 64, coef_ready random at 50% -> 512 handshakes in order with no loss or duplication; outputs stable while stalled; (FIFO + in-flight) never exceeds 2.
- Wrap: offset 0xFE, word_count 4 -> reads at 0xFE, 0xFF, 0x00, 0x01 in order; coef_last on the final coefficient of word 0x01.
- Reset mid-run: rst=0 after 10 handshakes of a 32-word run -> next cycle all outputs 0 and state IDLE; a new start afterwards delivers from its own offset with coef_index restarting at 0.
- Edge requests: word_count 0 -> done pulse at T+1, no reads, no coef_valid. A start pulse during busy is ignored, the run count is unchanged, and only one done is produced.

Source files
------------

// File: rtl/poly_ram_reader_pkg.sv
// Shared definitions for the polynomial RAM reader.
// Holds the RAM word geometry, coefficient packing, counter widths and
// the reader FSM state encoding used by poly_ram_reader and word_fifo2.
package poly_ram_reader_pkg;

  localparam int DATA_W         = 96;
  localparam int ADDR_W         = 8;
  localparam int COEF_W         = 12;
  localparam int COEFS_PER_WORD = DATA_W / COEF_W;
  localparam int POLY_WORDS     = 32;
  // Word counters need one bit beyond ADDR_W so a 256-word run is exact.
  localparam int CNT_W          = ADDR_W + 1;
  localparam int LANE_W         = $clog2(COEFS_PER_WORD);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/word_fifo2.sv
// Two-entry synchronous word FIFO.
// Ports:
//   clk, rst        clock and synchronous active-low reset
//   push, push_data write a word at the tail
//   pop             drop the head word
//   pop_data        current head word (valid while !empty)
//   full, empty     occupancy flags
//   count           number of stored words (0..2)
module word_fifo2
  import poly_ram_reader_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr_reg;
  logic             rd_ptr_reg;
  logic [1:0]       count_reg;

  // Storage carries no reset; contents are only observed while count > 0.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (push) begin
        wr_ptr_reg <= ~wr_ptr_reg;
      end
      if (pop) begin
        rd_ptr_reg <= ~rd_ptr_reg;
      end
      count_reg <= count_reg + {1'b0, push} - {1'b0, pop};
    end
  end

  assign pop_data = mem[rd_ptr_reg];
  assign full     = (count_reg == 2'd2);
  assign empty    = (count_reg == 2'd0);
  assign count    = count_reg;

  no_overflow: assert property (@(posedge clk) disable iff (!rst) push |-> (!full || pop));
  no_underflow: assert property (@(posedge clk) disable iff (!rst) pop |-> !empty);

endmodule

// File: rtl/poly_ram_reader.sv
// Polynomial RAM reader: fetches word_count RAM words starting at
// r_start_offset and streams their packed coefficients, lowest first,
// on a valid/ready interface.
// Ports:
//   clk, rst            clock and synchronous active-low reset
//   start               run request, honoured only when idle
//   r_start_offset      first RAM word address
//   word_count          words to read (0..256)
//   ram_raddr/ram_rdata RAM read port, data one cycle after address
//   coef_valid/ready    output handshake
//   coef_data           coefficient value
//   coef_index          coefficient position within its polynomial
//   coef_last           final coefficient of the run
//   busy                high while a run is in progress
//   done                one-cycle pulse after the final handshake
module poly_ram_reader
  import poly_ram_reader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] r_start_offset,
  input  logic [CNT_W-1:0]  word_count,
  output logic [ADDR_W-1:0] ram_raddr,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              coef_valid,
  input  logic              coef_ready,
  output logic [COEF_W-1:0] coef_data,
  output logic [ADDR_W-1:0] coef_index,
  output logic              coef_last,
  output logic              busy,
  output logic              done
);

  state_t              state_reg;
  logic [ADDR_W-1:0]   offset_reg;
  logic [ADDR_W-1:0]   raddr_reg;
  logic [CNT_W-1:0]    count_reg;
  logic [CNT_W-1:0]    issued_reg;
  logic [CNT_W-1:0]    accepted_reg;
  logic [LANE_W-1:0]   lane_reg;
  logic [ADDR_W-1:0]   index_reg;
  // addr_phase_reg: address on the bus this cycle; data_phase_reg: its data
  // is on ram_rdata this cycle and is pushed at the coming edge.
  logic                addr_phase_reg;
  logic                data_phase_reg;
  logic                busy_reg;
  logic                done_reg;

  logic [DATA_W-1:0]   head_word;
  logic                fifo_full;
  logic                fifo_empty;
  logic [1:0]          fifo_count;
  logic [2:0]          occupancy;
  logic                can_issue;
  logic                handshake;
  logic                word_end;
  logic                final_handshake;
  logic [COEF_W-1:0]   lanes [COEFS_PER_WORD];

  // The FIFO head is the word being serialized; it is popped when its
  // last coefficient is accepted, exposing the next word with no bubble.
  word_fifo2 #(.WIDTH(DATA_W)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (data_phase_reg),
    .push_data (ram_rdata),
    .pop       (word_end),
    .pop_data  (head_word),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  generate
    for (genvar gi = 0; gi < COEFS_PER_WORD; gi++) begin : g_lane
      assign lanes[gi] = head_word[gi*COEF_W +: COEF_W];
    end
  endgenerate

  // Stored words plus reads still in the pipeline never exceed two, so a
  // returning read always finds room in the FIFO.
  assign occupancy       = {1'b0, fifo_count} + {2'b00, addr_phase_reg} + {2'b00, data_phase_reg};
  assign can_issue       = !fifo_full && (occupancy < 3'd2);
  assign handshake       = coef_valid && coef_ready;
  assign word_end        = handshake && (lane_reg == LANE_W'(COEFS_PER_WORD - 1));
  assign final_handshake = word_end && (accepted_reg == (count_reg - CNT_W'(1)));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg      <= ST_IDLE;
      offset_reg     <= '0;
      raddr_reg      <= '0;
      count_reg      <= '0;
      issued_reg     <= '0;
      accepted_reg   <= '0;
      lane_reg       <= '0;
      index_reg      <= '0;
      addr_phase_reg <= 1'b0;
      data_phase_reg <= 1'b0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
    end else begin
      data_phase_reg <= addr_phase_reg;
      addr_phase_reg <= 1'b0;

      if (handshake) begin
        lane_reg  <= lane_reg + LANE_W'(1);
        index_reg <= index_reg + ADDR_W'(1);
        if (word_end) begin
          accepted_reg <= accepted_reg + CNT_W'(1);
        end
      end

      case (state_reg)
        ST_IDLE: begin
          raddr_reg    <= '0;
          lane_reg     <= '0;
          index_reg    <= '0;
          accepted_reg <= '0;
          if (start) begin
            busy_reg <= 1'b1;
            if (word_count == '0) begin
              state_reg <= ST_DONE;
              done_reg  <= 1'b1;
            end else begin
              // First read goes out immediately; the FIFO is empty here.
              state_reg      <= ST_FETCH;
              offset_reg     <= r_start_offset;
              count_reg      <= word_count;
              raddr_reg      <= r_start_offset;
              addr_phase_reg <= 1'b1;
              issued_reg     <= CNT_W'(1);
            end
          end
        end
        ST_FETCH: begin
          if (issued_reg == count_reg) begin
            state_reg <= ST_DRAIN;
          end else if (can_issue) begin
            raddr_reg      <= offset_reg + issued_reg[ADDR_W-1:0];
            addr_phase_reg <= 1'b1;
            issued_reg     <= issued_reg + CNT_W'(1);
          end
        end
        ST_DRAIN: begin
          if (final_handshake) begin
            state_reg <= ST_DONE;
            done_reg  <= 1'b1;
          end
        end
        ST_DONE: begin
          state_reg <= ST_IDLE;
          raddr_reg <= '0;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign ram_raddr  = raddr_reg;
  assign coef_valid = !fifo_empty;
  assign coef_data  = coef_valid ? lanes[lane_reg] : '0;
  assign coef_index = coef_valid ? index_reg : '0;
  assign coef_last  = coef_valid && (lane_reg == LANE_W'(COEFS_PER_WORD - 1))
                      && (accepted_reg == (count_reg - CNT_W'(1)));
  assign busy       = busy_reg;
  assign done       = done_reg;

endmodule

// File: tb/tb_poly_ram_reader.sv
// Self-checking bench for poly_ram_reader: a RAM model with one-cycle
// read latency, a table of run requests, a reference stream built from
// the RAM contents, and hand-written reset/busy-start sequences.
module tb_poly_ram_reader;
  import poly_ram_reader_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] r_start_offset;
  logic [CNT_W-1:0]  word_count;
  logic [ADDR_W-1:0] ram_raddr;
  logic [DATA_W-1:0] ram_rdata;
  logic              coef_valid;
  logic              coef_ready;
  logic [COEF_W-1:0] coef_data;
  logic [ADDR_W-1:0] coef_index;
  logic              coef_last;
  logic              busy;
  logic              done;

  always #5 clk = ~clk;

  poly_ram_reader dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .r_start_offset (r_start_offset),
    .word_count     (word_count),
    .ram_raddr      (ram_raddr),
    .ram_rdata      (ram_rdata),
    .coef_valid     (coef_valid),
    .coef_ready     (coef_ready),
    .coef_data      (coef_data),
    .coef_index     (coef_index),
    .coef_last      (coef_last),
    .busy           (busy),
    .done           (done)
  );

  logic [DATA_W-1:0] mem [256];
  always @(posedge clk) ram_rdata <= mem[ram_raddr];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [COEF_W-1:0] data;
    logic [7:0]        index;
    logic              last;
  } coef_t;
  coef_t expq[$];

  typedef struct {
    int off;
    int cnt;
    int pct;
    bit poke;
  } vec_t;
  vec_t vecs[8];

  // Reference stream: word w of the run comes from address (off+w) mod 256,
  // coefficient k of it is bits [12k +: 12], index counts from 0 mod 256.
  task automatic build_expected(input int off, input int cnt);
    logic [DATA_W-1:0] w_data;
    coef_t c;
    expq.delete();
    for (int w = 0; w < cnt; w++) begin
      w_data = mem[(off + w) % 256];
      for (int k = 0; k < COEFS_PER_WORD; k++) begin
        c.data  = w_data[COEF_W*k +: COEF_W];
        c.index = 8'((w * COEFS_PER_WORD + k) % 256);
        c.last  = (w == cnt - 1) && (k == COEFS_PER_WORD - 1);
        expq.push_back(c);
      end
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_raddr"}, 96'(ram_raddr), 96'(0));
    check({tag, "_valid"}, 96'(coef_valid), 96'(0));
    check({tag, "_data"},  96'(coef_data), 96'(0));
    check({tag, "_index"}, 96'(coef_index), 96'(0));
    check({tag, "_last"},  96'(coef_last), 96'(0));
    check({tag, "_busy"},  96'(busy), 96'(0));
    check({tag, "_done"},  96'(done), 96'(0));
  endtask

  task automatic run_test(input int off, input int cnt, input int pct, input bit poke);
    int cyc;
    int done_cyc = -1;
    int first_valid = -1;
    int ndone = 0;
    int nhs = 0;
    int budget;
    int addrs[$];
    logic [7:0] last_addr = 8'h00;
    logic prev_valid = 1'b0;
    logic prev_ready = 1'b0;
    logic [COEF_W-1:0] prev_data = '0;
    logic [7:0] prev_index = '0;
    logic prev_last = 1'b0;
    coef_t e;

    build_expected(off, cnt);
    budget = 200 + cnt * 32;
    start          = 1'b1;
    r_start_offset = 8'(off);
    word_count     = 9'(cnt);
    coef_ready     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc   = 1;
    while (1) begin
      if (cyc == 1) begin
        check("busy_after_start", 96'(busy), 96'(1));
        if (cnt > 0) check("first_raddr", 96'(ram_raddr), 96'(off));
      end
      if (busy && !done && ram_raddr != last_addr) addrs.push_back(int'(ram_raddr));
      last_addr = ram_raddr;
      if (done) begin
        ndone++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (coef_valid && first_valid < 0) first_valid = cyc;
      if (prev_valid && !prev_ready) begin
        check("stall_valid", 96'(coef_valid), 96'(1));
        check("stall_data",  96'(coef_data), 96'(prev_data));
        check("stall_index", 96'(coef_index), 96'(prev_index));
        check("stall_last",  96'(coef_last), 96'(prev_last));
      end
      if (poke && cyc == 5) begin
        start          = 1'b1;
        word_count     = 9'd7;
        r_start_offset = 8'h00;
      end else if (poke && cyc == 6) begin
        start = 1'b0;
      end
      coef_ready = (pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < pct);
      if (coef_valid && coef_ready) begin
        nhs++;
        if (expq.size() == 0) begin
          check("handshake_overrun", 96'(nhs), 96'(cnt * COEFS_PER_WORD));
        end else begin
          e = expq.pop_front();
          check("coef_data",  96'(coef_data), 96'(e.data));
          check("coef_index", 96'(coef_index), 96'(e.index));
          check("coef_last",  96'(coef_last), 96'(e.last));
        end
      end
      prev_valid = coef_valid;
      prev_ready = coef_ready;
      prev_data  = coef_data;
      prev_index = coef_index;
      prev_last  = coef_last;
      if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
      if (cyc >= budget) begin
        check("run_timeout_done", 96'(ndone), 96'(1));
        break;
      end
      @(posedge clk); #1;
      cyc++;
    end
    coef_ready = 1'b1;

    check("done_pulses", 96'(ndone), 96'(1));
    check("handshakes", 96'(nhs), 96'(cnt * COEFS_PER_WORD));
    check("expected_left", 96'(expq.size()), 96'(0));
    if (pct >= 100) check("done_cycle", 96'(done_cyc), 96'((cnt == 0) ? 1 : 3 + COEFS_PER_WORD * cnt));
    if (cnt == 0) check("no_valid", 96'(first_valid), 96'(-1));
    else if (pct >= 100) check("first_valid_cycle", 96'(first_valid), 96'(3));
    if (off != 0) begin
      check("read_count", 96'(addrs.size()), 96'(cnt));
      for (int i = 0; i < addrs.size() && i < cnt; i++)
        check("read_addr", 96'(addrs[i]), 96'((off + i) % 256));
    end
    $display("run off=%02h words=%0d ready=%0d%% poke=%0d handshakes=%0d done_cycle=%0d",
             off, cnt, pct, poke, nhs, done_cyc);
  endtask

  task automatic reset_mid_run();
    int nhs = 0;
    int cyc = 0;
    start          = 1'b1;
    r_start_offset = 8'h50;
    word_count     = 9'd32;
    coef_ready     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (nhs < 10 && cyc < 200) begin
      if (coef_valid && coef_ready) nhs++;
      if (nhs < 10) begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    check("reset_run_handshakes", 96'(nhs), 96'(10));
    rst = 1'b0;
    @(posedge clk); #1;
    check_idle_outputs("midrun_reset");
    rst = 1'b1;
    @(posedge clk); #1;
    check("post_reset_busy", 96'(busy), 96'(0));
    $display("run mid-run reset after %0d handshakes", nhs);
  endtask

  initial begin
    rst            = 1'b0;
    start          = 1'b0;
    r_start_offset = '0;
    word_count     = '0;
    coef_ready     = 1'b1;
    for (int a = 0; a < 256; a++) mem[a] = {$urandom, $urandom, $urandom};
    for (int k = 0; k < COEFS_PER_WORD; k++) mem[8'h10][COEF_W*k +: COEF_W] = 12'(k + 1);

    vecs[0] = '{off: 'h10, cnt: 1,   pct: 100, poke: 1'b0};
    vecs[1] = '{off: 'h20, cnt: 32,  pct: 100, poke: 1'b0};
    vecs[2] = '{off: 'h40, cnt: 64,  pct: 50,  poke: 1'b0};
    vecs[3] = '{off: 'hFE, cnt: 4,   pct: 100, poke: 1'b0};
    vecs[4] = '{off: 'h00, cnt: 0,   pct: 100, poke: 1'b0};
    vecs[5] = '{off: 'h30, cnt: 8,   pct: 100, poke: 1'b1};
    vecs[6] = '{off: 'h05, cnt: 256, pct: 100, poke: 1'b0};
    vecs[7] = '{off: 'h00, cnt: 3,   pct: 70,  poke: 1'b0};

    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      run_test(vecs[i].off, vecs[i].cnt, vecs[i].pct, vecs[i].poke);
      repeat (2) @(posedge clk);
      #1;
    end

    reset_mid_run();
    run_test('h60, 2, 100, 1'b0);

    for (int i = 0; i < 4; i++) begin
      run_test(int'($urandom_range(0, 255)), int'($urandom_range(1, 40)),
               int'($urandom_range(30, 100)), 1'b0);
      @(posedge clk); #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
